// File: rtl/seq_add_pkg.sv
// Shared types and constants for the multi-cycle wide adder.
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned K_DEF = 4;

  // Chunk counter width: enough bits to hold K-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? 32'($clog2(k)) : 32'd1;
  endfunction

endpackage

// File: rtl/multi_bit_adder.sv
// N-bit propagate/generate adder; the per-chunk datapath of seq_wide_adder.
module multi_bit_adder #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         cin_i,
  output logic [n-1:0] s_o,
  output logic         cout_o
);

  logic [n-1:0] p;
  logic [n-1:0] g;
  logic [n:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Carry chain built from generate/propagate terms.
  always_comb begin
    c[0] = cin_i;
    for (int i = 0; i < int'(n); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s_o    = p ^ c[n-1:0];
  assign cout_o = c[n];

endmodule

// File: rtl/seq_wide_adder.sv
// Multi-cycle W = N*K bit adder reusing one N-bit adder, LSB chunk first.
// Optional feature macro: SEQ_ADD_SUB_EN adds a sub port (s = a - b).
module seq_wide_adder
  import seq_add_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic           sub,
`endif
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] s,
  output logic           cout
);

  localparam int unsigned W  = N * K;
  localparam int unsigned CW = cnt_width(K);
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [W-1:0]    s_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;

  logic [N-1:0]    chunk_a;
  logic [N-1:0]    chunk_b;
  logic [N-1:0]    chunk_s;
  logic            chunk_cout;

  // Select the current chunk of each latched operand.
  assign chunk_a = a_q[32'(cnt_q) * N +: N];
  assign chunk_b = b_q[32'(cnt_q) * N +: N];
  assign cnt_d   = cnt_q + CW'(1);

  multi_bit_adder #(
    .n (N)
  ) u_adder (
    .a_i    (chunk_a),
    .b_i    (chunk_b),
    .cin_i  (carry_q),
    .s_o    (chunk_s),
    .cout_o (chunk_cout)
  );

  // Sequencer: accept in IDLE/DONE, one chunk per cycle in RUN, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
`ifdef SEQ_ADD_SUB_EN
            // Subtract as a + ~b + 1; cin is ignored when sub is set.
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[32'(cnt_q) * N +: N] <= chunk_s;
          carry_q                  <= chunk_cout;
          if (cnt_q == CNT_LAST) begin
            cout_q  <= chunk_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed self-checking bench for seq_wide_adder (N=8, K=4).
// Define SEQ_ADD_SUB_EN to also exercise the subtract path.
module tb_seq_wide_adder;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;
  localparam int unsigned W = N * K;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SEQ_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  int n_cmp = 0;
  int n_err = 0;

  seq_wide_adder #(
    .N (N),
    .K (K)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SEQ_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full request: done must rise K edges after the accepting edge.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W-1:0] es, input logic ec);
    int edges;
    int bcnt;
    a = av; b = bv; cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~ci;
    edges = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && edges < 20) begin
      step();
      edges++;
      if (busy) bcnt++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_lat"},  64'(edges), 64'(K));
    check({tag, "_busy"}, 64'(bcnt), 64'(K));
    check({tag, "_s"},    64'(s), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    step();
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dcnt;
    logic [W-1:0] s_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    sub = 1'b0;
`endif
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_s",    64'(s),    64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    step();

    // Full carry ripple through every chunk.
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    // Mixed carries across bytes 0-2.
    run_op("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0);

    // Back-to-back with start held; operands changed mid-RUN.
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; start = 1'b1;
    step();
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1;
    repeat (3) step();
    check("b2b_early", 64'(done), 64'd0);
    step();
    check("b2b_d1",    64'(done), 64'd1);
    check("b2b_s1",    64'(s),    64'h3333_3333);
    check("b2b_c1",    64'(cout), 64'd0);
    step();
    check("b2b_gap_done", 64'(done), 64'd0);
    check("b2b_gap_busy", 64'(busy), 64'd1);
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = 1'b0;
    repeat (3) step();
    check("b2b_early2", 64'(done), 64'd0);
    step();
    check("b2b_d2", 64'(done), 64'd1);
    check("b2b_s2", 64'(s),    64'h0000_0001);
    check("b2b_c2", 64'(cout), 64'd1);
    start = 1'b0;
    step();
    check("b2b_idle_done", 64'(done), 64'd0);
    check("b2b_idle_busy", 64'(busy), 64'd0);

    // Reset during the second RUN cycle aborts the request.
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_s",    64'(s),    64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    dcnt = 0;
    repeat (6) begin
      step();
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    run_op("after_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);

    // Reset and start together: the start is dropped.
    a = 32'h0000_0001; b = 32'h0000_0001; rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    step();
    check("rst_start_idle", 64'(busy), 64'd0);

    // Start pulsed during RUN is ignored.
    a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 32'h7777_7777; b = 32'h1111_1111;
    step();
    start = 1'b0;
    dcnt = 0;
    s_seen = '0;
    repeat (12) begin
      if (done) begin
        dcnt++;
        s_seen = s;
      end
      step();
    end
    check("ign_done_cnt", 64'(dcnt), 64'd1);
    check("ign_s",        64'(s_seen), 64'h0001_0000);

`ifdef SEQ_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 32'h0000_0002, 1'b1);
    sub = 1'b0;
    run_op("sub_off", 32'd3, 32'd4, 1'b1, 32'h0000_0008, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
